// File: rtl/exp6_unidade_controle_if.sv
// Handshake bundle between the sequence-game control unit and its surroundings
// (player inputs, datapath compare flags, datapath controls and result flags).
interface exp6_unidade_controle_if #(
  parameter int MAX_VIDAS = 3
);
  localparam int VW = $clog2(MAX_VIDAS + 1);

  logic          jogar;
  logic          modo;
  logic          jogada;
  logic          igualE;
  logic          igualL;
  logic          fimE;
  logic          fimL;

  logic          zeraE;
  logic          contaE;
  logic          zeraL;
  logic          contaL;
  logic          zeraR;
  logic          registraR;
  logic          mostra_led;
  logic          acertou;
  logic          errou;
  logic          pronto;
  logic          deu_timeout;
  logic [VW-1:0] vidas;
  logic [3:0]    db_estado;

  // Environment side: player/datapath drive the inputs, observe the controls.
  modport master (
    output jogar, modo, jogada, igualE, igualL, fimE, fimL,
    input  zeraE, contaE, zeraL, contaL, zeraR, registraR, mostra_led,
           acertou, errou, pronto, deu_timeout, vidas, db_estado
  );

  // Control unit side.
  modport slave (
    input  jogar, modo, jogada, igualE, igualL, fimE, fimL,
    output zeraE, contaE, zeraL, contaL, zeraR, registraR, mostra_led,
           acertou, errou, pronto, deu_timeout, vidas, db_estado
  );
endinterface

// File: rtl/exp6_unidade_controle.sv
// Control unit for the sequence-memory game: optional show mode that replays
// the sequence on the LEDs before each round, multiple lives, and one shared
// timer for show/gap durations and the move timeout.
//
// state          | code | meaning
// inicial        | 0    | idle, datapath cleared
// preparacao     | 1    | load lives, latch mode
// nova_seq       | 2    | show finished, rewind E before the player repeats
// espera         | 3    | waiting for a player move (timeout running)
// registra       | 4    | load move into R
// comparacao     | 5    | compare move with memory[E]
// proximo        | 6    | advance E within the round
// proxima_seq    | 7    | grow round (L+1), rewind E
// mostra         | 8    | light memory[E] on the LEDs
// intervalo      | 9    | dark gap between shown items
// fim_acerto     | A    | game won
// proximo_mostra | B    | advance E during the show
// perde_vida     | C    | life lost, rewind E, replay same round
// fim_timeout    | D    | game lost by timeout
// fim_erro       | E    | game lost, no lives left
module exp6_unidade_controle #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SHOW_CYCLES    = 1000,
  parameter int GAP_CYCLES     = 250,
  parameter int MAX_VIDAS      = 3
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  exp6_unidade_controle_if.slave bus
);
  localparam int VW   = $clog2(MAX_VIDAS + 1);
  localparam int TMAX = (TIMEOUT_CYCLES > SHOW_CYCLES) ?
                        ((TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES) :
                        ((SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES);
  localparam int TW   = $clog2(TMAX);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    NOVA_SEQ       = 4'h2,
    ESPERA         = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMO        = 4'h6,
    PROXIMA_SEQ    = 4'h7,
    MOSTRA         = 4'h8,
    INTERVALO      = 4'h9,
    FIM_ACERTO     = 4'hA,
    PROXIMO_MOSTRA = 4'hB,
    PERDE_VIDA     = 4'hC,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERRO       = 4'hE
  } estado_t;

  // Raw 4-bit register so an illegal code (F) is representable and recoverable.
  logic [3:0]    estado_q;
  estado_t       estado_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [VW-1:0] vidas_q, vidas_d;
  logic          modo_q, modo_d;
  logic          timer_conta;

  // State, timer, lives and latched mode registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      estado_q <= INICIAL;
      timer_q  <= '0;
      vidas_q  <= '0;
      modo_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      timer_q  <= timer_d;
      vidas_q  <= vidas_d;
      modo_q   <= modo_d;
    end
  end

  // Next-state logic.
  always_comb begin
    estado_d = INICIAL;
    case (estado_q)
      INICIAL:        estado_d = bus.jogar ? PREPARACAO : INICIAL;
      PREPARACAO:     estado_d = bus.modo ? MOSTRA : ESPERA;
      MOSTRA: begin
        if (timer_q == TW'(SHOW_CYCLES - 1))
          estado_d = bus.igualL ? NOVA_SEQ : INTERVALO;
        else
          estado_d = MOSTRA;
      end
      INTERVALO:      estado_d = (timer_q == TW'(GAP_CYCLES - 1)) ? PROXIMO_MOSTRA : INTERVALO;
      PROXIMO_MOSTRA: estado_d = MOSTRA;
      NOVA_SEQ:       estado_d = ESPERA;
      ESPERA: begin
        // A move arriving on the last timeout cycle still counts.
        if (bus.jogada)
          estado_d = REGISTRA;
        else if (timer_q == TW'(TIMEOUT_CYCLES - 1))
          estado_d = FIM_TIMEOUT;
        else
          estado_d = ESPERA;
      end
      REGISTRA:       estado_d = COMPARACAO;
      COMPARACAO: begin
        if (!bus.igualE)
          estado_d = (vidas_q > VW'(1)) ? PERDE_VIDA : FIM_ERRO;
        else if (!bus.igualL)
          estado_d = PROXIMO;
        else
          estado_d = bus.fimL ? FIM_ACERTO : PROXIMA_SEQ;
      end
      PROXIMO:        estado_d = ESPERA;
      PROXIMA_SEQ,
      PERDE_VIDA:     estado_d = modo_q ? MOSTRA : ESPERA;
      FIM_ACERTO:     estado_d = bus.jogar ? PREPARACAO : FIM_ACERTO;
      FIM_TIMEOUT:    estado_d = bus.jogar ? PREPARACAO : FIM_TIMEOUT;
      FIM_ERRO:       estado_d = bus.jogar ? PREPARACAO : FIM_ERRO;
      default:        estado_d = INICIAL;
    endcase
  end

  // Timer restarts on every state change; only the timed states advance it.
  always_comb begin
    timer_conta = (estado_q == ESPERA) || (estado_q == MOSTRA) || (estado_q == INTERVALO);
    timer_d     = '0;
    if ((estado_d == estado_q) && timer_conta)
      timer_d = timer_q + TW'(1);
  end

  // Lives are reloaded at game start and spent when entering perde_vida, so the
  // decremented count is already visible while in that state.
  always_comb begin
    vidas_d = vidas_q;
    modo_d  = modo_q;
    if (estado_q == PREPARACAO) begin
      vidas_d = VW'(MAX_VIDAS);
      modo_d  = bus.modo;
    end else if (estado_d == PERDE_VIDA) begin
      vidas_d = vidas_q - VW'(1);
    end
  end

  // Moore output decode.
  always_comb begin
    bus.zeraE       = 1'b0;
    bus.contaE      = 1'b0;
    bus.zeraL       = 1'b0;
    bus.contaL      = 1'b0;
    bus.zeraR       = 1'b0;
    bus.registraR   = 1'b0;
    bus.mostra_led  = 1'b0;
    bus.acertou     = 1'b0;
    bus.errou       = 1'b0;
    bus.pronto      = 1'b0;
    bus.deu_timeout = 1'b0;
    bus.db_estado   = estado_q;
    case (estado_q)
      INICIAL, PREPARACAO: begin
        bus.zeraE = 1'b1;
        bus.zeraL = 1'b1;
        bus.zeraR = 1'b1;
      end
      NOVA_SEQ, PERDE_VIDA: bus.zeraE = 1'b1;
      PROXIMA_SEQ: begin
        bus.zeraE  = 1'b1;
        bus.contaL = 1'b1;
      end
      PROXIMO, PROXIMO_MOSTRA: bus.contaE = 1'b1;
      REGISTRA:   bus.registraR  = 1'b1;
      MOSTRA:     bus.mostra_led = 1'b1;
      FIM_ACERTO: begin
        bus.acertou = 1'b1;
        bus.pronto  = 1'b1;
      end
      FIM_TIMEOUT: begin
        bus.deu_timeout = 1'b1;
        bus.errou       = 1'b1;
        bus.pronto      = 1'b1;
      end
      FIM_ERRO: begin
        bus.errou  = 1'b1;
        bus.pronto = 1'b1;
      end
      ESPERA, COMPARACAO, INTERVALO: ;
      default: bus.db_estado = 4'hF;
    endcase
  end

  assign bus.vidas = vidas_q;

endmodule

// File: tb/tb_exp6_unidade_controle.sv
// Directed bench for the game control unit with small timer values.
module tb_exp6_unidade_controle;
  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  exp6_unidade_controle_if #(.MAX_VIDAS(2)) bus ();

  exp6_unidade_controle #(
    .TIMEOUT_CYCLES(8),
    .SHOW_CYCLES   (4),
    .GAP_CYCLES    (2),
    .MAX_VIDAS     (2)
  ) dut (
    .clock_i(clock),
    .reset_i(reset),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.jogar = 0; bus.modo = 0; bus.jogada = 0;
    bus.igualE = 0; bus.igualL = 0; bus.fimE = 0; bus.fimL = 0;
    tick(); tick();
    chk("rst_estado", bus.db_estado, 0);
    chk("rst_zeraE", bus.zeraE, 1);
    chk("rst_zeraL", bus.zeraL, 1);
    chk("rst_zeraR", bus.zeraR, 1);
    chk("rst_vidas", bus.vidas, 0);
    chk("rst_led", bus.mostra_led, 0);
    chk("rst_pronto", bus.pronto, 0);
    chk("rst_contaE", bus.contaE, 0);

    // Normal game, no show mode, two rounds to fimL
    reset = 0; bus.jogar = 1; tick(); bus.jogar = 0;
    chk("prep", bus.db_estado, 1);
    tick();
    chk("espera1", bus.db_estado, 3);
    chk("vidas_load", bus.vidas, 2);
    bus.jogada = 1; bus.igualE = 1; bus.igualL = 1; bus.fimL = 0;
    tick(); bus.jogada = 0;
    chk("registra", bus.db_estado, 4);
    chk("registraR", bus.registraR, 1);
    tick(); chk("comparacao", bus.db_estado, 5);
    tick(); chk("proxima_seq", bus.db_estado, 7);
    chk("contaL", bus.contaL, 1);
    chk("ps_zeraE", bus.zeraE, 1);
    tick(); chk("espera2", bus.db_estado, 3);
    bus.jogada = 1; bus.igualL = 0;
    tick(); bus.jogada = 0; tick(); tick();
    chk("proximo", bus.db_estado, 6);
    chk("contaE", bus.contaE, 1);
    tick(); chk("espera3", bus.db_estado, 3);
    bus.jogada = 1; bus.igualL = 1; bus.fimL = 1;
    tick(); bus.jogada = 0; tick(); tick();
    chk("fim_acerto", bus.db_estado, 4'hA);
    chk("acertou", bus.acertou, 1);
    chk("acerto_pronto", bus.pronto, 1);
    chk("acerto_errou", bus.errou, 0);
    chk("acerto_vidas", bus.vidas, 2);
    bus.fimL = 0; bus.igualE = 0; bus.igualL = 0;

    // Timeout after exactly 8 cycles in espera
    bus.jogar = 1; tick(); bus.jogar = 0;
    chk("restart_prep", bus.db_estado, 1);
    tick(); chk("to_espera", bus.db_estado, 3);
    repeat (7) tick();
    chk("to_cycle7", bus.db_estado, 3);
    tick();
    chk("fim_timeout", bus.db_estado, 4'hD);
    chk("deu_timeout", bus.deu_timeout, 1);
    chk("to_errou", bus.errou, 1);
    chk("to_pronto", bus.pronto, 1);
    chk("to_vidas", bus.vidas, 2);

    // Move on the last timeout cycle wins, then two wrong moves
    bus.jogar = 1; tick(); bus.jogar = 0; tick();
    repeat (7) tick();
    chk("tie_espera", bus.db_estado, 3);
    bus.jogada = 1; tick(); bus.jogada = 0;
    chk("tie_registra", bus.db_estado, 4);
    tick(); chk("wrong_comp", bus.db_estado, 5);
    tick();
    chk("perde_vida", bus.db_estado, 4'hC);
    chk("pv_vidas", bus.vidas, 1);
    chk("pv_zeraE", bus.zeraE, 1);
    chk("pv_zeraL", bus.zeraL, 0);
    tick(); chk("pv_espera", bus.db_estado, 3);
    bus.jogada = 1; tick(); bus.jogada = 0; tick(); tick();
    chk("fim_erro", bus.db_estado, 4'hE);
    chk("erro_errou", bus.errou, 1);
    chk("erro_pronto", bus.pronto, 1);
    chk("erro_vidas", bus.vidas, 1);
    chk("erro_timeout", bus.deu_timeout, 0);
    bus.jogar = 1; tick(); bus.jogar = 0;
    chk("erro_restart", bus.db_estado, 1);
    tick();
    chk("restart_espera", bus.db_estado, 3);
    chk("restart_vidas", bus.vidas, 2);

    // Show mode with L=1: item 0, gap, item 1, then play
    reset = 1; tick(); reset = 0;
    bus.modo = 1; bus.jogar = 1; tick(); bus.jogar = 0;
    chk("show_prep", bus.db_estado, 1);
    tick(); bus.igualL = 0;
    for (int i = 0; i < 4; i++) begin
      chk("show0_led", bus.mostra_led, 1);
      chk("show0_estado", bus.db_estado, 8);
      tick();
    end
    chk("gap_estado", bus.db_estado, 9);
    chk("gap_led", bus.mostra_led, 0);
    tick(); chk("gap2_led", bus.mostra_led, 0);
    tick();
    chk("proximo_mostra", bus.db_estado, 4'hB);
    chk("pm_contaE", bus.contaE, 1);
    bus.igualL = 1; tick();
    for (int i = 0; i < 4; i++) begin
      chk("show1_led", bus.mostra_led, 1);
      tick();
    end
    chk("nova_seq", bus.db_estado, 2);
    chk("ns_zeraE", bus.zeraE, 1);
    tick(); chk("show_espera", bus.db_estado, 3);

    // jogar ignored mid-game; modo change has no effect
    bus.modo = 0; bus.jogar = 1; tick(); bus.jogar = 0;
    chk("jogar_ign", bus.db_estado, 3);
    bus.jogada = 1; bus.igualE = 1; bus.igualL = 1; bus.fimL = 0;
    tick(); bus.jogada = 0; tick(); tick();
    chk("show_ps", bus.db_estado, 7);
    tick(); chk("modo_latched", bus.db_estado, 8);

    // Reset in mostra has priority
    reset = 1; bus.jogar = 1; tick(); reset = 0; bus.jogar = 0;
    chk("rst_mid_estado", bus.db_estado, 0);
    chk("rst_mid_vidas", bus.vidas, 0);
    chk("rst_mid_led", bus.mostra_led, 0);

    // Illegal state recovery
    force dut.estado_q = 4'hF;
    #1;
    chk("illegal_db", bus.db_estado, 4'hF);
    release dut.estado_q;
    tick();
    chk("illegal_recover", bus.db_estado, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
